// File: rtl/mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// mem_pipe_stage
//
// MEM stage of the pipeline together with the MEM/WB pipeline register.
// It takes the EX/MEM register contents, performs loads and stores through
// a req/ack handshake to a multi-cycle data memory, and produces the MEM/WB
// write-back value that the EX forwarding muxes consume.
//
// While an access is outstanding the stage raises mem_stall so that the
// upstream stages hold. Upstream must keep the ex_mem_* inputs stable during
// a stall. Everything needed to finish the access is latched when the
// request is issued, so the stage never re-samples ex_mem_* while in REQ.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of REQ cycles without an ack before the
//                    access is abandoned and mem_timeout is pulsed.
//   ALIGN_CHECK    : 1 -> a word access with addr[1:0] != 0 is faulted
//                    (mem_misaligned); 0 -> the low address bits are ignored.
//
// Ports
//   clk                        in   rising-edge clock
//   reset                      in   asynchronous active-low reset
//   ex_mem_valid               in   EX/MEM slot holds a real instruction
//   ex_mem_alu_result[31:0]    in   ALU result / word address
//   ex_mem_store_data[31:0]    in   store data (forwarded reg2 path)
//   ex_mem_mem_read            in   load
//   ex_mem_mem_write           in   store (wins over mem_read)
//   ex_mem_mem_to_reg          in   write-back selects memory data
//   ex_mem_reg_write           in   instruction writes the register file
//   ex_mem_write_reg_addr[4:0] in   destination register
//   dmem_req                   out  memory request
//   dmem_we                    out  1 = write
//   dmem_addr[31:0]            out  word address
//   dmem_wdata[31:0]           out  write data
//   dmem_ack                   in   access complete, rdata valid same cycle
//   dmem_rdata[31:0]           in   read data
//   mem_stall                  out  upstream stages must hold
//   mem_wb_valid               out  MEM/WB slot valid
//   mem_wb_reg_write           out  register-file write enable
//   mem_wb_write_reg_addr[4:0] out  destination register
//   mem_wb_write_back_result   out  write-back data / forwarding source
//   mem_misaligned             out  one-cycle fault pulse, aligned with MEM/WB
//   mem_timeout                out  one-cycle fault pulse, aligned with MEM/WB
// ---------------------------------------------------------------------------
module mem_pipe_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic        ex_mem_mem_to_reg,
    input  logic        ex_mem_reg_write,
    input  logic [4:0]  ex_mem_write_reg_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_wb_valid,
    output logic        mem_wb_reg_write,
    output logic [4:0]  mem_wb_write_reg_addr,
    output logic [31:0] mem_wb_write_back_result,
    output logic        mem_misaligned,
    output logic        mem_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_timeoutCount;
    logic           r_isLoad;
    logic           r_regWrite;
    logic [4:0]     r_writeRegAddr;
    logic [31:0]    r_rdataLatched;

    logic           w_memop;
    logic           w_misaligned;
    logic           w_lastReqCycle;

    // A memory operation is a valid slot that reads or writes. The alignment
    // fault only applies to real memory operations.
    assign w_memop        = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    assign w_misaligned   = ALIGN_CHECK && (ex_mem_alu_result[1:0] != 2'b00);
    assign w_lastReqCycle = (r_timeoutCount == CW'(TIMEOUT_CYCLES - 1));

    // Stall is combinational so upstream holds in the very cycle an aligned
    // access is detected. In REQ the ack releases upstream on the same edge
    // that completes the access. The stall is forced low while reset is
    // asserted so that it drops immediately even if upstream still presents
    // a memory operation.
    always_comb begin
        mem_stall = 1'b0;
        if (reset) begin
            unique case (r_state)
                IDLE:    mem_stall = w_memop & ~w_misaligned;
                REQ:     mem_stall = ~dmem_ack;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    // Main FSM with the memory interface registers and the MEM/WB register.
    // IDLE either passes a non-memory instruction straight into MEM/WB,
    // faults a misaligned access, or issues a request and moves to REQ while
    // MEM/WB takes a bubble. REQ holds the request until ack or until the
    // timeout counter reaches its last cycle; an ack in that last cycle wins.
    // A store writes its address into the result field since it has no
    // register result of its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state                  <= IDLE;
            r_timeoutCount           <= '0;
            r_isLoad                 <= 1'b0;
            r_regWrite               <= 1'b0;
            r_writeRegAddr           <= '0;
            r_rdataLatched           <= '0;
            dmem_req                 <= 1'b0;
            dmem_we                  <= 1'b0;
            dmem_addr                <= '0;
            dmem_wdata               <= '0;
            mem_wb_valid             <= 1'b0;
            mem_wb_reg_write         <= 1'b0;
            mem_wb_write_reg_addr    <= '0;
            mem_wb_write_back_result <= '0;
            mem_misaligned           <= 1'b0;
            mem_timeout              <= 1'b0;
        end else begin
            mem_misaligned <= 1'b0;
            mem_timeout    <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_memop && w_misaligned) begin
                        mem_wb_valid             <= 1'b1;
                        mem_wb_reg_write         <= 1'b0;
                        mem_wb_write_reg_addr    <= ex_mem_write_reg_addr;
                        mem_wb_write_back_result <= ex_mem_alu_result;
                        mem_misaligned           <= 1'b1;
                    end else if (w_memop) begin
                        dmem_req         <= 1'b1;
                        dmem_we          <= ex_mem_mem_write;
                        dmem_addr        <= ex_mem_alu_result;
                        dmem_wdata       <= ex_mem_store_data;
                        r_isLoad         <= ~ex_mem_mem_write;
                        r_regWrite       <= ex_mem_reg_write;
                        r_writeRegAddr   <= ex_mem_write_reg_addr;
                        r_timeoutCount   <= '0;
                        r_state          <= REQ;
                        mem_wb_valid     <= 1'b0;
                        mem_wb_reg_write <= 1'b0;
                    end else begin
                        mem_wb_valid             <= ex_mem_valid;
                        mem_wb_reg_write         <= ex_mem_valid & ex_mem_reg_write;
                        mem_wb_write_reg_addr    <= ex_mem_write_reg_addr;
                        mem_wb_write_back_result <= ex_mem_mem_to_reg ? r_rdataLatched
                                                                      : ex_mem_alu_result;
                    end
                end

                REQ: begin
                    if (dmem_ack) begin
                        dmem_req              <= 1'b0;
                        r_state               <= IDLE;
                        mem_wb_valid          <= 1'b1;
                        mem_wb_write_reg_addr <= r_writeRegAddr;
                        if (r_isLoad) begin
                            mem_wb_reg_write         <= r_regWrite;
                            mem_wb_write_back_result <= dmem_rdata;
                            r_rdataLatched           <= dmem_rdata;
                        end else begin
                            mem_wb_reg_write         <= 1'b0;
                            mem_wb_write_back_result <= dmem_addr;
                        end
                    end else if (w_lastReqCycle) begin
                        dmem_req              <= 1'b0;
                        r_state               <= IDLE;
                        mem_wb_valid          <= 1'b1;
                        mem_wb_reg_write      <= 1'b0;
                        mem_wb_write_reg_addr <= r_writeRegAddr;
                        mem_timeout           <= 1'b1;
                    end else begin
                        r_timeoutCount   <= r_timeoutCount + CW'(1);
                        mem_wb_valid     <= 1'b0;
                        mem_wb_reg_write <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_pipe_stage
//
// Self-checking bench for mem_pipe_stage (TIMEOUT_CYCLES=4, ALIGN_CHECK=1).
// Each instruction is classified by the reference model as a plain ALU op,
// a misaligned access or a real access. For a real access the model derives
// the number of REQ cycles from the chosen ack delay (delay+1, capped at the
// timeout) and the final MEM/WB contents from the instruction itself; the
// memory responder acks after that delay.
// ---------------------------------------------------------------------------
module tb_mem_pipe_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_mem_valid = 1'b0;
    logic [31:0] ex_mem_alu_result = '0;
    logic [31:0] ex_mem_store_data = '0;
    logic        ex_mem_mem_read = 1'b0;
    logic        ex_mem_mem_write = 1'b0;
    logic        ex_mem_mem_to_reg = 1'b0;
    logic        ex_mem_reg_write = 1'b0;
    logic [4:0]  ex_mem_write_reg_addr = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall;
    logic        mem_wb_valid;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg_addr;
    logic [31:0] mem_wb_write_back_result;
    logic        mem_misaligned;
    logic        mem_timeout;

    int vecCount = 0;
    int missCount = 0;

    mem_pipe_stage #(
        .TIMEOUT_CYCLES(TO),
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ex_mem_valid(ex_mem_valid),
        .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_mem_to_reg(ex_mem_mem_to_reg),
        .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_write_reg_addr(ex_mem_write_reg_addr),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .mem_wb_valid(mem_wb_valid),
        .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_write_reg_addr(mem_wb_write_reg_addr),
        .mem_wb_write_back_result(mem_wb_write_back_result),
        .mem_misaligned(mem_misaligned),
        .mem_timeout(mem_timeout)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Guard against any unexpected hang in the stimulus sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every comparison and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Applies one instruction in IDLE and follows it to completion.
    // ackDelay is the REQ cycle index (0-based) in which the memory acks;
    // a delay of TO or more means the memory never acks in time.
    task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                                 input logic rd, input logic wr, input logic m2r, input logic rw,
                                 input logic [4:0] wa, input int ackDelay, input logic [31:0] rdata);
        logic memop;
        logic mis;
        logic isStore;
        int   reqCycles;
        logic timedOut;
        memop   = v & (rd | wr);
        mis     = memop && (alu[1:0] != 2'b00);
        isStore = wr;

        ex_mem_valid          = v;
        ex_mem_alu_result     = alu;
        ex_mem_store_data     = sd;
        ex_mem_mem_read       = rd;
        ex_mem_mem_write      = wr;
        ex_mem_mem_to_reg     = m2r;
        ex_mem_reg_write      = rw;
        ex_mem_write_reg_addr = wa;
        dmem_ack              = 1'($urandom_range(0, 1));
        dmem_rdata            = $urandom;

        @(negedge clk);
        checkOutput("idle_req", 32'(dmem_req), 32'(1'b0));
        if (!memop || mis) begin
            checkOutput("idle_stall", 32'(mem_stall), 32'(1'b0));
            @(posedge clk); #1;
            if (mis) begin
                checkOutput("mis_valid", 32'(mem_wb_valid), 32'(1'b1));
                checkOutput("mis_rw", 32'(mem_wb_reg_write), 32'(1'b0));
                checkOutput("mis_pulse", 32'(mem_misaligned), 32'(1'b1));
                checkOutput("mis_to", 32'(mem_timeout), 32'(1'b0));
            end else begin
                checkOutput("alu_valid", 32'(mem_wb_valid), 32'(v));
                checkOutput("alu_rw", 32'(mem_wb_reg_write), 32'(v & rw));
                checkOutput("alu_wa", 32'(mem_wb_write_reg_addr), 32'(wa));
                checkOutput("alu_result", mem_wb_write_back_result, alu);
                checkOutput("alu_mis", 32'(mem_misaligned), 32'(1'b0));
                checkOutput("alu_to", 32'(mem_timeout), 32'(1'b0));
            end
            checkOutput("post_req", 32'(dmem_req), 32'(1'b0));
        end else begin
            checkOutput("start_stall", 32'(mem_stall), 32'(1'b1));
            @(posedge clk); #1;
            reqCycles = (ackDelay < TO) ? ackDelay + 1 : TO;
            timedOut  = (ackDelay >= TO);
            for (int k = 0; k < reqCycles; k++) begin
                dmem_ack   = (k == ackDelay);
                dmem_rdata = (k == ackDelay) ? rdata : $urandom;
                @(negedge clk);
                checkOutput("req_req", 32'(dmem_req), 32'(1'b1));
                checkOutput("req_addr", dmem_addr, alu);
                checkOutput("req_we", 32'(dmem_we), 32'(isStore));
                checkOutput("req_wdata", dmem_wdata, sd);
                checkOutput("req_stall", 32'(mem_stall), 32'(k != ackDelay));
                checkOutput("req_bubble", 32'(mem_wb_valid), 32'(1'b0));
                checkOutput("req_bubble_rw", 32'(mem_wb_reg_write), 32'(1'b0));
                checkOutput("req_to", 32'(mem_timeout), 32'(1'b0));
                @(posedge clk); #1;
            end
            dmem_ack = 1'b0;
            checkOutput("done_req", 32'(dmem_req), 32'(1'b0));
            checkOutput("done_valid", 32'(mem_wb_valid), 32'(1'b1));
            checkOutput("done_wa", 32'(mem_wb_write_reg_addr), 32'(wa));
            checkOutput("done_to", 32'(mem_timeout), 32'(timedOut));
            checkOutput("done_mis", 32'(mem_misaligned), 32'(1'b0));
            if (timedOut) begin
                checkOutput("to_rw", 32'(mem_wb_reg_write), 32'(1'b0));
            end else if (isStore) begin
                checkOutput("st_rw", 32'(mem_wb_reg_write), 32'(1'b0));
                checkOutput("st_result", mem_wb_write_back_result, alu);
            end else begin
                checkOutput("ld_rw", 32'(mem_wb_reg_write), 32'(rw));
                checkOutput("ld_result", mem_wb_write_back_result, rdata);
            end
        end
    endtask

    initial begin
        logic [31:0] alu;
        logic        rd;
        logic        wr;
        int          kind;

        // Reset state
        #12;
        checkOutput("rst_req", 32'(dmem_req), 32'(1'b0));
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_wdata", dmem_wdata, 32'h0);
        checkOutput("rst_valid", 32'(mem_wb_valid), 32'(1'b0));
        checkOutput("rst_result", mem_wb_write_back_result, 32'h0);
        checkOutput("rst_stall", 32'(mem_stall), 32'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed cases");
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 0, 32'h0);
        applyStimulus(1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 2, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_0204, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 0, 32'h0);
        applyStimulus(1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 0, 32'h0);
        applyStimulus(1'b1, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 10, 32'h0);
        applyStimulus(1'b1, 32'h0000_0304, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 3, 32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h0000_0408, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 1, 32'h0);
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 0, 32'h0);

        // Reset in the second REQ cycle
        $display("[TB] reset during REQ");
        ex_mem_valid          = 1'b1;
        ex_mem_alu_result     = 32'h0000_0500;
        ex_mem_mem_read       = 1'b1;
        ex_mem_mem_write      = 1'b0;
        ex_mem_mem_to_reg     = 1'b1;
        ex_mem_reg_write      = 1'b1;
        ex_mem_write_reg_addr = 5'd10;
        dmem_ack              = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rq2_req", 32'(dmem_req), 32'(1'b1));
        reset = 1'b0;
        #1;
        checkOutput("arst_req", 32'(dmem_req), 32'(1'b0));
        checkOutput("arst_stall", 32'(mem_stall), 32'(1'b0));
        checkOutput("arst_addr", dmem_addr, 32'h0);
        checkOutput("arst_result", mem_wb_write_back_result, 32'h0);
        ex_mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 0, 32'h0);

        // Randomized instruction stream
        $display("[TB] random stream");
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 9));
            alu  = $urandom;
            if (kind <= 3) begin
                applyStimulus(1'b1, alu, $urandom, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                              5'($urandom), 0, 32'h0);
            end else begin
                do begin
                    rd = 1'($urandom_range(0, 1));
                    wr = 1'($urandom_range(0, 1));
                end while (!(rd | wr));
                if (kind == 9) begin
                    alu[1:0] = 2'($urandom_range(1, 3));
                end else begin
                    alu[1:0] = 2'b00;
                end
                applyStimulus(1'b1, alu, $urandom, rd, wr, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 5'($urandom),
                              int'($urandom_range(0, 5)), $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
